// File: rtl/washer_phase_timer.sv
// Washer phase timer: times each wash phase from the registered washer state,
// drives the actuators and returns a one-cycle phase-done pulse on 'control'.
module washer_phase_timer #(
  parameter int CNT_W     = 16,
  parameter int FILL_CYC  = 8,
  parameter int WASH_CYC  = 20,
  parameter int DRAIN_CYC = 6,
  parameter int RINSE_CYC = 12,
  parameter int SPIN_CYC  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             door_open,
  output logic             control,
  output logic             water_valve,
  output logic             motor,
  output logic             motor_fast,
  output logic             pump,
  output logic             door_lock,
  output logic             paused,
  output logic             fault,
  output logic [CNT_W-1:0] time_left
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_ILL   = 3'd7
  } wstate_e;

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC  - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYC  - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC  - 1);

  // Load value on phase entry: the pulse then lands exactly DUR edges later.
  function automatic logic [CNT_W-1:0] reload(input wstate_e s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      S_FILL:  v = FILL_LD;
      S_WASH:  v = WASH_LD;
      S_DRAIN: v = DRAIN_LD;
      S_RINSE: v = RINSE_LD;
      S_SPIN:  v = SPIN_LD;
      default: v = '0;
    endcase
    return v;
  endfunction

  wstate_e          st;
  logic             timed;

  wstate_e          prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fired_q, fired_d;
  logic             fault_q, fault_d;
  logic             control_q, control_d;
  logic             valve_q, valve_d;
  logic             motor_q, motor_d;
  logic             fast_q, fast_d;
  logic             pump_q, pump_d;
  logic             lock_q, lock_d;
  logic             paused_q, paused_d;

  assign st    = wstate_e'(state);
  assign timed = (st == S_FILL) || (st == S_WASH) || (st == S_DRAIN) ||
                 (st == S_RINSE) || (st == S_SPIN);

  always_comb begin
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    fired_d   = fired_q;
    fault_d   = fault_q;
    control_d = 1'b0;
    valve_d   = 1'b0;
    motor_d   = 1'b0;
    fast_d    = 1'b0;
    pump_d    = 1'b0;
    lock_d    = 1'b0;
    paused_d  = 1'b0;

    if (st == S_ILL) begin
      fault_d = 1'b1;
      cnt_d   = '0;
      fired_d = 1'b0;
      prev_d  = st;
    end else if (!timed) begin
      cnt_d   = '0;
      fired_d = 1'b0;
      prev_d  = st;
    end else begin
      lock_d   = 1'b1;
      paused_d = door_open;
      // Entry takes priority over both the pause hold and a due pulse.
      if (st != prev_q) begin
        cnt_d   = reload(st);
        fired_d = 1'b0;
        prev_d  = st;
      end else if (door_open) begin
        cnt_d   = cnt_q;
      end else if (cnt_q != '0) begin
        cnt_d   = cnt_q - CNT_W'(1);
      end else if (!fired_q) begin
        control_d = 1'b1;
        fired_d   = 1'b1;
      end

      if (!door_open) begin
        case (st)
          S_FILL:  valve_d = 1'b1;
          S_WASH:  motor_d = 1'b1;
          S_DRAIN: pump_d  = 1'b1;
          S_RINSE: begin
            valve_d = 1'b1;
            motor_d = 1'b1;
          end
          S_SPIN: begin
            motor_d = 1'b1;
            fast_d  = 1'b1;
            pump_d  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= S_IDLE;
      cnt_q     <= '0;
      fired_q   <= 1'b0;
      fault_q   <= 1'b0;
      control_q <= 1'b0;
      valve_q   <= 1'b0;
      motor_q   <= 1'b0;
      fast_q    <= 1'b0;
      pump_q    <= 1'b0;
      lock_q    <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      fired_q   <= fired_d;
      fault_q   <= fault_d;
      control_q <= control_d;
      valve_q   <= valve_d;
      motor_q   <= motor_d;
      fast_q    <= fast_d;
      pump_q    <= pump_d;
      lock_q    <= lock_d;
      paused_q  <= paused_d;
    end
  end

  assign control     = control_q;
  assign water_valve = valve_q;
  assign motor       = motor_q;
  assign motor_fast  = fast_q;
  assign pump        = pump_q;
  assign door_lock   = lock_q;
  assign paused      = paused_q;
  assign fault       = fault_q;
  assign time_left   = cnt_q;

endmodule

// File: tb/tb_washer_phase_timer.sv
// Directed bench for washer_phase_timer with FILL=4 and WASH=3 cycles.
module tb_washer_phase_timer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [2:0]       state;
  logic             door_open;
  logic             control;
  logic             water_valve;
  logic             motor;
  logic             motor_fast;
  logic             pump;
  logic             door_lock;
  logic             paused;
  logic             fault;
  logic [CNT_W-1:0] time_left;

  washer_phase_timer #(
    .CNT_W(CNT_W), .FILL_CYC(4), .WASH_CYC(3),
    .DRAIN_CYC(6), .RINSE_CYC(12), .SPIN_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .door_open(door_open),
    .control(control), .water_valve(water_valve), .motor(motor),
    .motor_fast(motor_fast), .pump(pump), .door_lock(door_lock),
    .paused(paused), .fault(fault), .time_left(time_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {control, water_valve, motor, motor_fast, pump, door_lock, paused, fault}
  typedef struct {
    logic [2:0]       st;
    logic             door;
    logic [7:0]       flags;
    logic [CNT_W-1:0] tl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [7:0] F_OFF    = 8'b0000_0000;
  localparam logic [7:0] F_FILL   = 8'b0100_0100;
  localparam logic [7:0] F_FILLP  = 8'b1100_0100;
  localparam logic [7:0] F_WASH   = 8'b0010_0100;
  localparam logic [7:0] F_WASHP  = 8'b1010_0100;
  localparam logic [7:0] F_HOLD   = 8'b0000_0110;
  localparam logic [7:0] F_DRAIN  = 8'b0000_1100;
  localparam logic [7:0] F_RINSE  = 8'b0110_0100;
  localparam logic [7:0] F_SPIN   = 8'b0011_1100;
  localparam logic [7:0] F_FLT    = 8'b0000_0001;
  localparam logic [7:0] F_FLTF   = 8'b0100_0101;

  function automatic logic [7:0] flags_now();
    return {control, water_valve, motor, motor_fast, pump, door_lock, paused, fault};
  endfunction

  task automatic add(input logic [2:0] s, input logic d, input logic [7:0] f,
                     input int tl);
    vec_t v;
    v.st = s; v.door = d; v.flags = f; v.tl = CNT_W'(tl);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] f, input int tl);
    n_checks++;
    if (flags_now() !== f) begin
      n_fail++;
      $display("FAIL %s flags: got %b expected %b", name, flags_now(), f);
    end
    n_checks++;
    if (time_left !== CNT_W'(tl)) begin
      n_fail++;
      $display("FAIL %s time_left: got %0d expected %0d", name, time_left, tl);
    end
  endtask

  task automatic drive_edge(input logic [2:0] s, input logic d);
    @(negedge clk);
    state = s;
    door_open = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: FILL countdown and pulse
    add(3'd1, 1'b0, F_FILL, 3);
    add(3'd1, 1'b0, F_FILL, 2);
    add(3'd1, 1'b0, F_FILL, 1);
    add(3'd1, 1'b0, F_FILL, 0);
    add(3'd1, 1'b0, F_FILLP, 0);
    // 2: no repeat pulse while FILL held
    for (int i = 0; i < 10; i++) add(3'd1, 1'b0, F_FILL, 0);
    // actuator map and a pause in DRAIN
    add(3'd0, 1'b0, F_OFF, 0);
    add(3'd3, 1'b0, F_DRAIN, 5);
    add(3'd3, 1'b0, F_DRAIN, 4);
    add(3'd3, 1'b1, F_HOLD, 4);
    add(3'd3, 1'b0, F_DRAIN, 3);
    add(3'd4, 1'b0, F_RINSE, 11);
    add(3'd5, 1'b0, F_SPIN, 9);
    add(3'd6, 1'b0, F_OFF, 0);
    // 3: WASH paused at time_left=1
    add(3'd2, 1'b0, F_WASH, 2);
    add(3'd2, 1'b0, F_WASH, 1);
    for (int i = 0; i < 5; i++) add(3'd2, 1'b1, F_HOLD, 1);
    add(3'd2, 1'b0, F_WASH, 0);
    add(3'd2, 1'b0, F_WASHP, 0);
    add(3'd2, 1'b0, F_WASH, 0);
    add(3'd0, 1'b0, F_OFF, 0);
    // 4: FILL->WASH on the edge FILL would pulse
    add(3'd1, 1'b0, F_FILL, 3);
    add(3'd1, 1'b0, F_FILL, 2);
    add(3'd1, 1'b0, F_FILL, 1);
    add(3'd1, 1'b0, F_FILL, 0);
    add(3'd2, 1'b0, F_WASH, 2);
    add(3'd2, 1'b0, F_WASH, 1);
    add(3'd2, 1'b0, F_WASH, 0);
    add(3'd2, 1'b0, F_WASHP, 0);
    add(3'd0, 1'b0, F_OFF, 0);
    // 5: illegal state sets sticky fault
    add(3'd7, 1'b0, F_FLT, 0);
    add(3'd0, 1'b0, F_FLT, 0);
    add(3'd1, 1'b0, F_FLTF, 3);

    rst = 1'b1;
    state = 3'd0;
    door_open = 1'b0;
    #12;
    check("reset", F_OFF, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_edge(vecs[i].st, vecs[i].door);
      check($sformatf("vec%0d", i), vecs[i].flags, int'(vecs[i].tl));
    end

    // 5 (cont.): reset clears fault
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_clears_fault", F_OFF, 0);
    @(negedge clk);
    state = 3'd5;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("spin_entry", F_SPIN, 9);

    // 6: async reset mid-SPIN at time_left=5, then fresh entry
    for (int k = 8; k >= 5; k--) begin
      drive_edge(3'd5, 1'b0);
      check($sformatf("spin_tl%0d", k), F_SPIN, k);
    end
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_mid_spin", F_OFF, 0);
    @(negedge clk);
    rst = 1'b0;
    state = 3'd5;
    @(posedge clk);
    #1;
    check("spin_reentry", F_SPIN, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
